// File: rtl/alu_pkg.sv
// Shared op-code constants for the RV32I execute-stage ALU.
// Codes are {funct7[5], funct3} so the decoder can forward them unchanged.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter for SLL/SRL/SRA; only the 5-bit shift amount is used.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] d1,
    input  logic [4:0]      shamt,
    input  logic            dir,
    input  logic            arith,
    output logic [XLEN-1:0] res
);

    always_comb begin
        res = d1;
        if (dir == SHIFT_LEFT) begin
            res = d1 << shamt;
        end else if (arith) begin
            res = $unsigned($signed(d1) >>> shamt);
        end else begin
            res = d1 >> shamt;
        end
    end

endmodule

// File: rtl/alu.sv
// Single-cycle RV32I integer ALU: combinational result registered every clk edge.
// Unused op codes produce zero.
module alu
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] d1,
    input  logic [XLEN-1:0] d2,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] dout
);

    logic [XLEN-1:0] shift_res;
    logic [XLEN-1:0] result;
    logic            shift_dir;
    logic            shift_arith;

    assign shift_dir   = (op == OP_SLL) ? SHIFT_LEFT : SHIFT_RIGHT;
    assign shift_arith = (op == OP_SRA);

    alu_shifter u_shifter (
        .d1    (d1),
        .shamt (d2[4:0]),
        .dir   (shift_dir),
        .arith (shift_arith),
        .res   (shift_res)
    );

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = d1 + d2;
            OP_SUB:  result = d1 - d2;
            OP_SLL,
            OP_SRL,
            OP_SRA:  result = shift_res;
            OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(d1) < $signed(d2))};
            OP_SLTU: result = {{(XLEN-1){1'b0}}, (d1 < d2)};
            OP_XOR:  result = d1 ^ d2;
            OP_OR:   result = d1 | d2;
            OP_AND:  result = d1 & d2;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else begin
            dout <= result;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes model results, monitor pops one per edge.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [3:0]  op;
    logic [31:0] dout;

    typedef struct {
        logic [31:0] exp;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    alu dut (
        .clk  (clk),
        .rst  (rst),
        .d1   (d1),
        .d2   (d2),
        .op   (op),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built from the arithmetic meaning of each operation.
    function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        int     s  = int'(b % 32);
        case (o)
            4'd0:    return 32'(ua + ub);
            4'd8:    return 32'(ua - ub);
            4'd1:    return 32'(ua * (longint'(1) << s));
            4'd5:    return 32'(ua / (longint'(1) << s));
            4'd13:   return 32'(sa >>> s);
            4'd2:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd3:    return (ua < ub) ? 32'd1 : 32'd0;
            4'd4:    return a ^ b;
            4'd6:    return a | b;
            4'd7:    return a & b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        op = o;
        d1 = a;
        d2 = b;
        e.exp = model(o, a, b);
        e.op  = o;
        e.a   = a;
        e.b   = b;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst) begin
            n_checks++;
            if (dout === 32'h0) n_pass++;
            else $display("FAIL reset_hold dout=%h exp=00000000", dout);
        end else if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (dout === e.exp) n_pass++;
            else $display("FAIL op=%b d1=%h d2=%h dout=%h exp=%h", e.op, e.a, e.b, dout, e.exp);
        end
    end

    initial begin
        rst = 1'b0;
        op  = 4'd0;
        d1  = 32'd0;
        d2  = 32'd0;

        issue(4'b0000, 32'd3, 32'd4);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (dout === 32'h0) n_pass++;
        else $display("FAIL async_reset dout=%h exp=00000000", dout);

        // Inputs toggling under reset must not reach dout.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op = 4'b0000;
            d1 = $urandom | 32'h1;
            d2 = $urandom;
        end
        @(negedge clk);
        rst = 1'b0;
        op  = 4'b0000;
        d1  = 32'd5;
        d2  = 32'd7;
        begin
            exp_t e;
            e.exp = 32'd12; e.op = 4'b0000; e.a = 32'd5; e.b = 32'd7;
            q.push_back(e);
        end

        issue(4'b0101, 32'hFFFF_FFF6, 32'h1);
        issue(4'b1101, 32'hFFFF_FFF6, 32'h1);
        issue(4'b0001, 32'h0000_000F, 32'hFFFF_FFE4);
        issue(4'b1101, 32'h8000_0000, 32'hFFFF_FFE4);
        issue(4'b0101, 32'h8000_0000, 32'hFFFF_FFE4);
        issue(4'b0101, 32'h8765_4321, 32'h0);
        issue(4'b1101, 32'h8765_4321, 32'hFFFF_FFE0);
        issue(4'b0000, 32'hFFFF_FFFF, 32'h1);
        issue(4'b1000, 32'h0, 32'h1);
        issue(4'b0010, 32'hFFFF_FFFF, 32'h1);
        issue(4'b0011, 32'hFFFF_FFFF, 32'h1);
        issue(4'b0010, 32'h1234_5678, 32'h1234_5678);
        issue(4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00);
        issue(4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00);
        issue(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00);
        issue(4'b1111, 32'hF0F0_F0F0, 32'hFF00_FF00);
        issue(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        for (int i = 0; i < 300; i++) begin
            logic [3:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            o = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = {a[31], 31'h0} | (a & 32'hFF);
            if ($urandom_range(0, 3) == 0) b = a;
            issue(o, a, b);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
